// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
//   Shared constants and helpers for the clock-enable / flash divider family.
//
//   DEF_CLK_FREQ_HZ : default input clock frequency in Hz
//   DEF_OUT_FREQ_HZ : default flash frequency in Hz
//   half_count()    : clock cycles per half period of the output wave
//                     (truncating division); returns 0 for an unusable pair
//                     so that callers can reject it at elaboration.
// -----------------------------------------------------------------------------
package clk_div_pkg;

   localparam int DEF_CLK_FREQ_HZ = 100_000_000;
   localparam int DEF_OUT_FREQ_HZ = 2;

   function automatic int half_count(input int clk_hz, input int out_hz);
      int half;
      // A zero or negative frequency yields 0, which the top rejects.
      if (clk_hz <= 0 || out_hz <= 0) begin
         half = 0;
      end else begin
         half = clk_hz / (2 * out_hz);
      end
      return half;
   endfunction

endpackage : clk_div_pkg

// File: rtl/clk_2hz_mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
//   Modulo-MOD up counter with a synchronous active-high reset.
//   Counts 0..MOD-1 on cycles where inc=1 and flags the cycle that wraps.
//
//   Parameters : MOD   - modulus (>= 1); MOD == 1 keeps count at 0
//                WIDTH - counter width, must hold MOD-1
//   Ports      : clk   - system clock, rising edge
//                rst   - synchronous reset, active high (count -> 0)
//                inc   - advance the count this cycle
//                count - current count value (registered)
//                wrap  - inc is set and count is at MOD-1; the next edge
//                        returns count to 0 (combinational from inc/count)
// -----------------------------------------------------------------------------
module mod_counter #(
   parameter int MOD   = 5,
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] count,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

   logic at_last;

   always_comb begin
      at_last = (count == LAST);
      wrap    = inc && at_last;
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values of the others, independent of block order.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc) begin
         if (at_last) begin
            count <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule : mod_counter

// File: rtl/clk_2hz.sv
// -----------------------------------------------------------------------------
// clk_2hz
//   Divides clk down to a 50% duty square wave "flash" at OUT_FREQ_HZ and
//   emits a one-cycle "tick" on the cycle flash rises.
//
//   Parameters : CLK_FREQ_HZ - input clock frequency (Hz)
//                OUT_FREQ_HZ - flash frequency (Hz)
//                HALF = CLK_FREQ_HZ / (2*OUT_FREQ_HZ) cycles per half period;
//                HALF < 1 stops elaboration.
//   Ports      : clk   - system clock, rising edge
//                rst   - synchronous reset, active high; clears count,
//                        flash and tick and wins over en and the wrap
//                en    - count enable (only with CLK_2HZ_PAUSE_EN defined);
//                        en=0 freezes count and flash, tick stays 0
//                flash - registered square wave
//                tick  - registered pulse, high in the cycle flash is 1
//                        after a 0->1 change
//   Macro      : CLK_2HZ_PAUSE_EN - adds the en port; without it the
//                divider runs every cycle.
// -----------------------------------------------------------------------------
module clk_2hz
   import clk_div_pkg::*;
#(
   parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
   parameter int OUT_FREQ_HZ = DEF_OUT_FREQ_HZ
) (
   input  logic clk,
   input  logic rst,
`ifdef CLK_2HZ_PAUSE_EN
   input  logic en,
`endif
   output logic flash,
   output logic tick
);

   localparam int HALF  = half_count(CLK_FREQ_HZ, OUT_FREQ_HZ);
   // Keep the counter legal even for a rejected HALF so the only
   // elaboration message is the fatal below.
   localparam int MOD   = (HALF < 1) ? 1 : HALF;
   localparam int WIDTH = (MOD > 1) ? $clog2(MOD) : 1;

   if (HALF < 1) begin : g_bad_params
      $fatal(1, "clk_2hz: CLK_FREQ_HZ=%0d OUT_FREQ_HZ=%0d gives HALF=%0d (< 1)",
             CLK_FREQ_HZ, OUT_FREQ_HZ, HALF);
   end

   logic             inc;
   logic             wrap;
   logic [WIDTH-1:0] cnt;

`ifdef CLK_2HZ_PAUSE_EN
   assign inc = en;
`else
   assign inc = 1'b1;
`endif

   mod_counter #(
      .MOD   (MOD),
      .WIDTH (WIDTH)
   ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc),
      .count (cnt),
      .wrap  (wrap)
   );

   // tick is loaded with the old ~flash on each wrap, so it is set only when
   // flash is going 0->1 and cleared on every other cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         flash <= 1'b0;
         tick  <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (wrap) begin
            flash <= ~flash;
            tick  <= ~flash;
         end
      end
   end

endmodule : clk_2hz

// File: tb/tb_clk_2hz.sv
// -----------------------------------------------------------------------------
// tb_clk_2hz
//   Directed bench for clk_2hz. dut runs with HALF=5 (20 Hz clock, 2 Hz
//   flash); dut1 runs with HALF=1 (2 Hz clock, 1 Hz flash). Both share clk
//   and have separate resets. The pause scenario is built only when
//   CLK_2HZ_PAUSE_EN is defined.
// -----------------------------------------------------------------------------
module tb_clk_2hz;

   logic clk = 1'b0;
   logic rst;
   logic rst1;
   logic en;
   logic flash;
   logic tick;
   logic flash1;
   logic tick1;

   int n_vec = 0;
   int n_bad = 0;
   int n_ticks;

   always #5 clk = ~clk;

   clk_2hz #(
      .CLK_FREQ_HZ (20),
      .OUT_FREQ_HZ (2)
   ) dut (
      .clk   (clk),
      .rst   (rst),
`ifdef CLK_2HZ_PAUSE_EN
      .en    (en),
`endif
      .flash (flash),
      .tick  (tick)
   );

   clk_2hz #(
      .CLK_FREQ_HZ (2),
      .OUT_FREQ_HZ (1)
   ) dut1 (
      .clk   (clk),
      .rst   (rst1),
`ifdef CLK_2HZ_PAUSE_EN
      .en    (1'b1),
`endif
      .flash (flash1),
      .tick  (tick1)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Advance one rising edge, then sample 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst  = 1'b1;
      rst1 = 1'b1;
      en   = 1'b1;

      // Reset held for 3 edges: everything cleared.
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_flash", 32'(flash), 0);
         check("rst_tick",  32'(tick),  0);
         check("rst_cnt",   32'(dut.cnt), 0);
      end
      rst = 1'b0;

      // Edges 1..4 after release: counting up, flash still low.
      for (int n = 1; n <= 4; n++) begin
         step();
         check("up_flash", 32'(flash), 0);
         check("up_tick",  32'(tick),  0);
         check("up_cnt",   32'(dut.cnt), 32'(n));
      end
      // Edge 5: first rise, tick with it, counter wrapped.
      step();
      check("rise1_flash", 32'(flash), 1);
      check("rise1_tick",  32'(tick),  1);
      check("rise1_cnt",   32'(dut.cnt), 0);

      // Free run, edges 6..45: flash high on edges 5..9, 15..19, ...
      // tick only on edges 15, 25, 35, 45.
      n_ticks = 0;
      for (int n = 6; n <= 45; n++) begin
         step();
         check("run_flash", 32'(flash), 32'((n / 5) % 2));
         check("run_tick",  32'(tick),  32'((n % 10) == 5));
         if (tick === 1'b1) n_ticks++;
      end
      check("run_tick_count", 32'(n_ticks), 4);

      // Mid-period reset 3 edges after the rise at edge 45.
      for (int k = 1; k <= 3; k++) begin
         step();
         check("pre_rst_flash", 32'(flash), 1);
         check("pre_rst_cnt",   32'(dut.cnt), 32'(k));
      end
      rst = 1'b1;
      step();
      check("mid_rst_flash", 32'(flash), 0);
      check("mid_rst_tick",  32'(tick),  0);
      check("mid_rst_cnt",   32'(dut.cnt), 0);
      rst = 1'b0;
      for (int n = 1; n <= 4; n++) begin
         step();
         check("re_up_flash", 32'(flash), 0);
         check("re_up_tick",  32'(tick),  0);
      end
      step();
      check("re_rise_flash", 32'(flash), 1);
      check("re_rise_tick",  32'(tick),  1);

`ifdef CLK_2HZ_PAUSE_EN
      // Pause 7 cycles at count=2: rise moves from edge 5 to edge 12.
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      step();
      check("pause_start_cnt", 32'(dut.cnt), 2);
      en = 1'b0;
      for (int i = 0; i < 7; i++) begin
         step();
         check("pause_flash", 32'(flash), 0);
         check("pause_tick",  32'(tick),  0);
         check("pause_cnt",   32'(dut.cnt), 2);
      end
      en = 1'b1;
      for (int n = 3; n <= 4; n++) begin
         step();
         check("resume_flash", 32'(flash), 0);
         check("resume_cnt",   32'(dut.cnt), 32'(n));
      end
      step();
      check("pause_rise_flash", 32'(flash), 1);
      check("pause_rise_tick",  32'(tick),  1);
`endif

      // HALF=1 instance: was held in reset so far.
      check("h1_rst_flash", 32'(flash1), 0);
      check("h1_rst_tick",  32'(tick1),  0);
      check("h1_rst_cnt",   32'(dut1.cnt), 0);
      rst1 = 1'b0;
      for (int n = 1; n <= 6; n++) begin
         step();
         check("h1_flash", 32'(flash1), 32'(n % 2));
         check("h1_tick",  32'(tick1),  32'(n % 2));
         check("h1_cnt",   32'(dut1.cnt), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule : tb_clk_2hz

// File: doc/clk_2hz.md
CLK_2HZ -- requirements
Module: clk_2hz

Interface
- REQ-001 The module SHALL have parameter `CLK_FREQ_HZ`, default 100_000_000, giving the input clock frequency in Hz.
- REQ-002 The module SHALL have parameter `OUT_FREQ_HZ`, default 2, giving the `flash` frequency in Hz.
- REQ-003 The module SHALL have port `clk`, input, 1 bit: the single system clock; all logic is on its rising edge.
- REQ-004 The module SHALL have port `rst`, input, 1 bit: reset, synchronous and active-high.
- REQ-005 The module SHALL have port `en`, input, 1 bit: count enable; the port exists only when `CLK_2HZ_PAUSE_EN` is defined.
- REQ-006 The module SHALL have port `flash`, output, 1 bit: square wave at `OUT_FREQ_HZ`, 50% duty, registered.
- REQ-007 The module SHALL have port `tick`, output, 1 bit: one-`clk`-cycle pulse, registered, asserted on the cycle in which `flash` goes 0->1.

Function
- REQ-008 The module SHALL compute HALF = `CLK_FREQ_HZ` / (2 * `OUT_FREQ_HZ`), using integer division that truncates.
- REQ-009 The internal counter SHALL be max(1, $clog2(HALF)) bits wide and count 0..HALF-1.
- REQ-010 On each enabled cycle with count < HALF-1, count SHALL increment by 1, and `flash` SHALL hold.
- REQ-011 On an enabled cycle with count == HALF-1, count SHALL wrap to 0 and `flash` SHALL invert on the same edge.
- REQ-012 `tick` SHALL be 1 exactly in the cycle after an edge where `flash` went 0->1, and 0 otherwise (no pulse on 1->0).
- REQ-013 Latency: the first `flash` rise SHALL occur on the HALF-th enabled rising edge after `rst` deasserts, and the full period SHALL be 2*HALF enabled cycles.
- REQ-014 If HALF == 1, `flash` SHALL toggle every enabled cycle and the counter SHALL stay at 0.
- REQ-015 If HALF < 1 (`OUT_FREQ_HZ` > `CLK_FREQ_HZ`/2, or either parameter is 0), elaboration SHALL fail with a fatal message.
- REQ-016 The module SHALL have no combinational path from any input to any output.

Reset
- REQ-017 While `rst`=1 at a rising edge: count SHALL be 0, `flash` SHALL be 0 and `tick` SHALL be 0.
- REQ-018 `rst` SHALL have priority over `en` and over the wrap condition.
- REQ-019 Reset asserted mid-period SHALL abandon the current phase; counting SHALL restart from 0 with `flash` at 0.
- REQ-020 No initial-value statements SHALL be relied on; the state is undefined until the first reset.

Configuration
- REQ-021 Macro `CLK_2HZ_PAUSE_EN` defined: the `en` port SHALL exist.
- REQ-022 With the macro defined and `en`=0: count and `flash` SHALL hold and `tick` SHALL be 0.
- REQ-023 With the macro defined, the cycles counted in REQ-013 SHALL be only those with `en`=1.
- REQ-024 Macro `CLK_2HZ_PAUSE_EN` undefined: there SHALL be no `en` port, and the counter SHALL behave as permanently enabled.

Structure
- REQ-025 Package `clk_div_pkg` SHALL hold the default constants `DEF_CLK_FREQ_HZ` = 100_000_000 and `DEF_OUT_FREQ_HZ` = 2.
- REQ-026 Package `clk_div_pkg` SHALL also hold the function `half_count(clk_hz, out_hz)` that returns HALF.
- REQ-027 The design SHALL use one sub-module, `mod_counter` (parameters MOD and WIDTH; ports clk, rst, inc, count, wrap), for the modulo-HALF counter.
- REQ-028 The `flash`/`tick` registers SHALL live in `clk_2hz`, which instantiates `mod_counter`.

Verification (params CLK_FREQ_HZ=20, OUT_FREQ_HZ=2, so HALF=5)
- REQ-029 Scenario: hold `rst`=1 for 3 cycles, then release -> `flash`=0 and `tick`=0 during reset; `flash` rises on the 5th edge after release; `tick`=1 for exactly 1 cycle then.
- REQ-030 Scenario: free-run for 40 cycles -> `flash` has period 10, high 5 and low 5; 4 `tick` pulses, spaced 10 cycles apart.
- REQ-031 Scenario: assert `rst` 3 cycles after a `flash` rise -> next edge gives `flash`=0 and count=0; after release the next rise is at edge 5.
- REQ-032 Scenario (`CLK_2HZ_PAUSE_EN` defined): drop `en` for 7 cycles at count=2 -> `flash` holds and `tick`=0 throughout; the rise is delayed by exactly 7 cycles.
- REQ-033 Scenario: CLK_FREQ_HZ=2, OUT_FREQ_HZ=1 (HALF=1) -> `flash` toggles every cycle and `tick` pulses every 2 cycles.
- REQ-034 Scenario: CLK_FREQ_HZ=3, OUT_FREQ_HZ=2 -> elaboration fails fatally.
